// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Converts one W-bit word per start request into D packed BCD digits. Results
// that do not fit in D digits saturate to all nines and raise ovf.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous, active-high reset
//   start  conversion request, honoured only when idle
//   bin    binary input word, captured on the accepted start cycle
//   busy   high while converting (SHIFT and DONE states)
//   done   one-cycle pulse marking a bcd/ovf update
//   bcd    result, digit k in bits [4k+3:4k], k=0 least significant
//   ovf    result exceeded 10^D-1, held until the next done
//   blank  (BCD_BLANK_EN only) leading-zero blanking per digit, blank[0] always 0
//
// Optional feature macro: BCD_BLANK_EN adds the blank output.
module bin2bcd_seq #(
   parameter int unsigned W = 8,
   parameter int unsigned D = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   bin,
   output logic           busy,
   output logic           done,
   output logic [4*D-1:0] bcd,
   output logic           ovf
`ifdef BCD_BLANK_EN
   ,
   output logic [D-1:0]   blank
`endif
);

   localparam int unsigned BW = 4 * D;
   localparam int unsigned CW = $clog2(W + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [W-1:0]  sr;
   logic [BW-1:0] acc;
   logic [BW-1:0] acc_adj;
   logic [BW-1:0] acc_sh;
   logic          ovf_int;
   logic          ovf_sh;
   logic [CW-1:0] count;
   logic          last_c;

   // Per-digit add-3 correction ahead of the shift; digits never carry into each other.
   always_comb begin
      acc_adj = acc;
      for (int k = 0; k < int'(D); k++) begin
         if (acc[4*k +: 4] >= 4'd5) begin
            acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
         end
      end
   end

   // A one leaving the accumulator top means the value no longer fits in D digits.
   assign acc_sh = {acc_adj[BW-2:0], sr[W-1]};
   assign ovf_sh = ovf_int | acc_adj[BW-1];
   assign last_c = (count == CW'(W - 1));

`ifdef BCD_BLANK_EN
   logic [D-1:0] blank_nx;
   logic         zero_above;

   // Digit k blanks only when it and every more-significant digit are zero.
   always_comb begin
      blank_nx   = '0;
      zero_above = 1'b1;
      for (int k = int'(D) - 1; k >= 1; k--) begin
         zero_above  = zero_above & (acc_sh[4*k +: 4] == 4'd0);
         blank_nx[k] = zero_above & ~ovf_sh;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last_c) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and registered outputs; results load on the edge entering DONE
   // so bcd/ovf are valid in the same cycle as the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
         ovf     <= 1'b0;
         sr      <= '0;
         acc     <= '0;
         ovf_int <= 1'b0;
         count   <= '0;
`ifdef BCD_BLANK_EN
         blank   <= '0;
`endif
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state_nx == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  sr      <= bin;
                  acc     <= '0;
                  ovf_int <= 1'b0;
                  count   <= '0;
               end
            end
            SHIFT: begin
               sr      <= sr << 1;
               acc     <= acc_sh;
               ovf_int <= ovf_sh;
               count   <= count + CW'(1);
               if (last_c) begin
                  ovf <= ovf_sh;
                  bcd <= ovf_sh ? {D{4'h9}} : acc_sh;
`ifdef BCD_BLANK_EN
                  blank <= blank_nx;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed vector table, back-to-back, reset-abort
// and random conversions on W=8 instances with D=3 and D=2.
module tb_bin2bcd_seq;

   localparam int unsigned W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start3, start2;
   logic [7:0]  bin3, bin2;
   logic        busy3, done3, ovf3;
   logic        busy2, done2, ovf2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;
`ifdef BCD_BLANK_EN
   logic [2:0]  blank3;
   logic [1:0]  blank2;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(8), .D(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin(bin3),
      .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
`ifdef BCD_BLANK_EN
      , .blank(blank3)
`endif
   );

   bin2bcd_seq #(.W(8), .D(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
`ifdef BCD_BLANK_EN
      , .blank(blank2)
`endif
   );

   typedef struct {
      int          d;
      logic [7:0]  v;
      logic [11:0] eb;
      logic        eo;
      logic [2:0]  ebl;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits by division; saturate when value >= 10^d.
   function automatic void model(input int v, input int d, output logic [11:0] b,
                                 output logic o, output logic [2:0] bl);
      int lim;
      int p;
      lim = 1;
      for (int k = 0; k < d; k++) lim = lim * 10;
      b  = '0;
      bl = '0;
      o  = (v >= lim);
      p  = 1;
      for (int k = 0; k < d; k++) begin
         if (o) b[4*k +: 4] = 4'h9;
         else begin
            b[4*k +: 4] = 4'((v / p) % 10);
            if (k > 0 && v < p) bl[k] = 1'b1;
         end
         p = p * 10;
      end
   endfunction

   function automatic logic get_busy(input int d);
      return (d == 3) ? busy3 : busy2;
   endfunction

   function automatic logic get_done(input int d);
      return (d == 3) ? done3 : done2;
   endfunction

   // One conversion on the selected instance with latency and result checks.
   task automatic convert(input int d, input logic [7:0] v, input logic [11:0] eb,
                          input logic eo, input logic [2:0] ebl, input string tag);
      int cyc;
      @(negedge clk);
      if (d == 3) begin start3 = 1'b1; bin3 = v; end
      else        begin start2 = 1'b1; bin2 = v; end
      @(posedge clk); #1;
      start3 = 1'b0;
      start2 = 1'b0;
      bin3   = 8'($urandom);
      bin2   = 8'($urandom);
      cyc    = 1;
      while (!get_done(d) && cyc < 40) begin
         chk({tag, " busy"}, 32'(get_busy(d)), 32'd1);
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(W + 1));
      chk({tag, " busy_in_done"}, 32'(get_busy(d)), 32'd1);
      if (d == 3) begin
         chk({tag, " bcd"}, 32'(bcd3), 32'(eb));
         chk({tag, " ovf"}, 32'(ovf3), 32'(eo));
`ifdef BCD_BLANK_EN
         chk({tag, " blank"}, 32'(blank3), 32'(ebl));
`endif
      end else begin
         chk({tag, " bcd"}, 32'(bcd2), 32'(eb));
         chk({tag, " ovf"}, 32'(ovf2), 32'(eo));
`ifdef BCD_BLANK_EN
         chk({tag, " blank"}, 32'(blank2), 32'(ebl));
`endif
      end
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 32'(get_done(d)), 32'd0);
      chk({tag, " idle"}, 32'(get_busy(d)), 32'd0);
      if (d == 3) chk({tag, " bcd_hold"}, 32'(bcd3), 32'(eb));
      else        chk({tag, " bcd_hold"}, 32'(bcd2), 32'(eb));
   endtask

   initial begin
      logic [7:0]  seq [4];
      logic [11:0] eb;
      logic        eo;
      logic [2:0]  ebl;
      int          idx, cyc, last, hold, d;
      logic [7:0]  v;

      vecs[0]  = '{3, 8'd0,   12'h000, 1'b0, 3'b110};
      vecs[1]  = '{3, 8'd255, 12'h255, 1'b0, 3'b000};
      vecs[2]  = '{3, 8'd99,  12'h099, 1'b0, 3'b100};
      vecs[3]  = '{3, 8'd10,  12'h010, 1'b0, 3'b100};
      vecs[4]  = '{3, 8'd5,   12'h005, 1'b0, 3'b110};
      vecs[5]  = '{3, 8'd40,  12'h040, 1'b0, 3'b100};
      vecs[6]  = '{3, 8'd200, 12'h200, 1'b0, 3'b000};
      vecs[7]  = '{2, 8'd100, 12'h099, 1'b1, 3'b000};
      vecs[8]  = '{2, 8'd99,  12'h099, 1'b0, 3'b000};
      vecs[9]  = '{2, 8'd7,   12'h007, 1'b0, 3'b010};
      vecs[10] = '{2, 8'd255, 12'h099, 1'b1, 3'b000};

      rst = 1'b1; start3 = 1'b0; start2 = 1'b0; bin3 = '0; bin2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy3", 32'(busy3), 32'd0);
      chk("rst done3", 32'(done3), 32'd0);
      chk("rst bcd3",  32'(bcd3),  32'd0);
      chk("rst ovf3",  32'(ovf3),  32'd0);
      chk("rst busy2", 32'(busy2), 32'd0);
      chk("rst bcd2",  32'(bcd2),  32'd0);
`ifdef BCD_BLANK_EN
      chk("rst blank3", 32'(blank3), 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         convert(vecs[i].d, vecs[i].v, vecs[i].eb, vecs[i].eo, vecs[i].ebl,
                 $sformatf("vec%0d", i));
      end

      // Back-to-back: start held high, bin garbage while busy.
      seq[0] = 8'd37; seq[1] = 8'd200; seq[2] = 8'd37; seq[3] = 8'd200;
      @(negedge clk);
      start3 = 1'b1; bin3 = seq[0];
      idx = 0; cyc = 0; last = 0; hold = 1;
      while (idx < 4 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (hold > 0) hold--;
         else bin3 = 8'($urandom);
         if (done3) begin
            model(int'(seq[idx]), 3, eb, eo, ebl);
            chk($sformatf("b2b%0d bcd", idx), 32'(bcd3), 32'(eb));
            if (idx > 0) chk($sformatf("b2b%0d spacing", idx), 32'(cyc - last), 32'(W + 2));
            last = cyc;
            idx++;
            if (idx < 4) begin bin3 = seq[idx]; hold = 2; end
            else start3 = 1'b0;
         end
      end
      chk("b2b count", 32'(idx), 32'd4);
      start3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset during the fourth SHIFT cycle aborts the conversion.
      @(negedge clk);
      start3 = 1'b1; bin3 = 8'd123;
      @(posedge clk); #1;
      start3 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort no_done", 32'(done3), 32'd0);
         chk("abort bcd_stable", 32'(bcd3), 32'h200);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort busy", 32'(busy3), 32'd0);
      chk("abort done", 32'(done3), 32'd0);
      chk("abort bcd",  32'(bcd3),  32'd0);
      chk("abort ovf",  32'(ovf3),  32'd0);
      rst = 1'b0;
      convert(3, 8'd45, 12'h045, 1'b0, 3'b100, "after_abort");

      // Random conversions against the reference model.
      for (int i = 0; i < 30; i++) begin
         d = ($urandom_range(1) == 0) ? 2 : 3;
         v = 8'($urandom);
         model(int'(v), d, eb, eo, ebl);
         convert(d, v, eb, eo, ebl, $sformatf("rnd%0d_d%0d_v%0d", i, d, v));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
